// File: rtl/subsurf_pkg.sv
// Shared constants, header field layout and loader FSM encoding for the subsurf mesh pipeline.
package subsurf_pkg;

  localparam int unsigned DEPTH      = 512;
  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned VERT_WORDS = 3;

  localparam int unsigned HDR_V_LSB = 0;
  localparam int unsigned HDR_V_W   = 8;
  localparam int unsigned HDR_F_LSB = 8;
  localparam int unsigned HDR_F_W   = 16;

  localparam int unsigned ERR_SIZE = 0;
  localparam int unsigned ERR_IDX  = 1;

  typedef enum logic [2:0] {
    ST_HEADER,
    ST_VERTS,
    ST_FACES,
    ST_START,
    ST_DRAIN
  } loader_state_e;

endpackage

// File: rtl/face_idx_check.sv
// Flags a quad face word whose vertex indices reach past the mesh vertex count.
module face_idx_check (
  input  logic [31:0] word,
  input  logic [7:0]  v_num,
  output logic        bad
);

  always_comb begin
    bad = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (word[i*8 +: 8] >= v_num) bad = 1'b1;
    end
  end

endmodule

// File: rtl/mesh_loader.sv
// Streams a quad mesh into RAM1 (header, vertices, faces) and starts the neighbor stage.
// Optional face index range check: define MESH_LOADER_IDX_CHECK_EN.
module mesh_loader #(
  parameter int unsigned ADDR_W = subsurf_pkg::ADDR_W,
  parameter int unsigned DEPTH  = subsurf_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              RAM1_EN,
  output logic [3:0]        RAM1_WE,
  output logic [ADDR_W-1:0] RAM1_A,
  output logic [31:0]       RAM1_Di,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic              neighbor_start
);
  import subsurf_pkg::*;

  loader_state_e     state;
  logic [ADDR_W-1:0] addr;
  logic [9:0]        vert_cnt;
  logic [15:0]       face_cnt;
  logic              beat;
  logic              idx_bad;
  logic [7:0]        hdr_v;
  logic [15:0]       hdr_f;
  logic [31:0]       total;
  logic              size_bad;

  assign s_ready  = (state != ST_START);
  assign beat     = s_valid & s_ready;
  assign hdr_v    = s_data[HDR_V_LSB +: HDR_V_W];
  assign hdr_f    = s_data[HDR_F_LSB +: HDR_F_W];
  assign total    = 32'd1 + VERT_WORDS * 32'(hdr_v) + 32'(hdr_f);
  assign size_bad = (hdr_v == '0) || (hdr_f == '0) || (total > DEPTH);

`ifdef MESH_LOADER_IDX_CHECK_EN
  logic [7:0] v_num;

  always_ff @(posedge clk) begin
    if (rst) v_num <= '0;
    else if (state == ST_HEADER && beat) v_num <= hdr_v;
  end

  face_idx_check u_face_idx_check (
    .word  (s_data),
    .v_num (v_num),
    .bad   (idx_bad)
  );
`else
  assign idx_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_HEADER;
      addr           <= '0;
      vert_cnt       <= '0;
      face_cnt       <= '0;
      RAM1_EN        <= 1'b0;
      RAM1_WE        <= '0;
      RAM1_A         <= '0;
      RAM1_Di        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= '0;
      neighbor_start <= 1'b0;
    end else begin
      RAM1_EN        <= 1'b0;
      RAM1_WE        <= '0;
      RAM1_A         <= '0;
      RAM1_Di        <= '0;
      neighbor_start <= 1'b0;
      case (state)
        ST_HEADER: begin
          if (beat) begin
            // Header is always written, even when it fails the size check.
            RAM1_EN <= 1'b1;
            RAM1_WE <= 4'hF;
            RAM1_A  <= '0;
            RAM1_Di <= s_data;
            done    <= 1'b0;
            busy    <= 1'b1;
            if (size_bad || s_last) begin
              err   <= 2'b01;
              state <= s_last ? ST_HEADER : ST_DRAIN;
            end else begin
              err      <= '0;
              addr     <= ADDR_W'(1);
              vert_cnt <= 10'(VERT_WORDS * 32'(hdr_v));
              face_cnt <= hdr_f;
              state    <= ST_VERTS;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ST_VERTS: begin
          if (beat) begin
            if (s_last) begin
              err[ERR_SIZE] <= 1'b1;
              busy          <= 1'b0;
              state         <= ST_HEADER;
            end else begin
              RAM1_EN  <= 1'b1;
              RAM1_WE  <= 4'hF;
              RAM1_A   <= addr;
              RAM1_Di  <= s_data;
              addr     <= addr + ADDR_W'(1);
              vert_cnt <= vert_cnt - 10'd1;
              if (vert_cnt == 10'd1) state <= ST_FACES;
            end
          end
        end
        ST_FACES: begin
          if (beat) begin
            if (idx_bad) begin
              err[ERR_IDX] <= 1'b1;
              busy         <= 1'b0;
              state        <= s_last ? ST_HEADER : ST_DRAIN;
            end else if (face_cnt == 16'd1 && s_last) begin
              RAM1_EN <= 1'b1;
              RAM1_WE <= 4'hF;
              RAM1_A  <= addr;
              RAM1_Di <= s_data;
              state   <= ST_START;
            end else if (face_cnt == 16'd1 || s_last) begin
              // Framing error: either s_last missing on the final face or early.
              err[ERR_SIZE] <= 1'b1;
              busy          <= 1'b0;
              state         <= s_last ? ST_HEADER : ST_DRAIN;
            end else begin
              RAM1_EN  <= 1'b1;
              RAM1_WE  <= 4'hF;
              RAM1_A   <= addr;
              RAM1_Di  <= s_data;
              addr     <= addr + ADDR_W'(1);
              face_cnt <= face_cnt - 16'd1;
            end
          end
        end
        ST_START: begin
          neighbor_start <= 1'b1;
          done           <= 1'b1;
          busy           <= 1'b0;
          state          <= ST_HEADER;
        end
        ST_DRAIN: begin
          busy <= 1'b0;
          if (beat && s_last) state <= ST_HEADER;
        end
        default: state <= ST_HEADER;
      endcase
    end
  end

endmodule
